// File: rtl/mem_request_arbiter.sv
// Arbitrates demand misses against queued prefetches onto one memory read port and
// tracks outstanding reads in order. Define MEM_REQ_DEDUP_EN for block-address dedup.
module mem_request_arbiter #(
  parameter int unsigned AW        = 16,
  parameter int unsigned ORL_DEPTH = 4,
  parameter int unsigned PF_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dem_valid,
  input  logic [AW-1:0] dem_addr,
  output logic          dem_stall,
  output logic          dem_inflight,
  input  logic          pf_valid,
  input  logic [AW-1:0] pf_addr,
  output logic          pf_full,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  output logic          ret_valid,
  output logic [AW-1:0] ret_addr,
  output logic          ret_is_demand,
  output logic          err_underflow
);

  localparam int unsigned OPW = $clog2(ORL_DEPTH);
  localparam int unsigned OCW = OPW + 1;
  localparam int unsigned PPW = $clog2(PF_DEPTH);
  localparam int unsigned PCW = PPW + 1;

  logic [AW-1:0]       orl_addr_q [ORL_DEPTH];
  logic [AW-1:0]       orl_addr_d [ORL_DEPTH];
  logic [ORL_DEPTH-1:0] orl_dem_q, orl_dem_d;
  logic [OPW-1:0]      orl_rd_q, orl_rd_d, orl_wr_q, orl_wr_d;
  logic [OCW-1:0]      orl_cnt_q, orl_cnt_d;
  logic [AW-1:0]       pf_addr_q [PF_DEPTH];
  logic [AW-1:0]       pf_addr_d [PF_DEPTH];
  logic [PF_DEPTH-1:0] pf_kill_q, pf_kill_d;
  logic [PPW-1:0]      pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;
  logic [PCW-1:0]      pf_cnt_q, pf_cnt_d;
  logic                err_q, err_d;

  logic orl_empty, orl_full, orl_pop, orl_room, orl_push;
  logic pf_head_vld, pf_head_kill, pf_issue, pf_pop, pf_push;
  logic dem_issue, dem_orl_hit, pf_dup;
  logic [PF_DEPTH-1:0] kill_set;

  assign orl_empty = (orl_cnt_q == '0);
  assign orl_full  = (orl_cnt_q == OCW'(ORL_DEPTH));
  assign orl_pop   = mem_ready && !orl_empty;
  assign orl_room  = !orl_full || mem_ready;

  assign pf_head_vld  = (pf_cnt_q != '0);
  assign pf_head_kill = pf_kill_q[pf_rd_q];
  assign pf_full      = (pf_cnt_q == PCW'(PF_DEPTH));

  // Issue priority: demand, then live prefetch head, else drop a killed head.
  assign dem_inflight = dem_valid && dem_orl_hit;
  assign dem_issue    = orl_room && dem_valid && !dem_inflight;
  assign dem_stall    = dem_valid && !orl_room && !dem_inflight;
  assign pf_issue     = orl_room && !dem_issue && pf_head_vld && !pf_head_kill;
  assign pf_pop       = orl_room && !dem_issue && pf_head_vld;
  assign mem_en       = dem_issue || pf_issue;
  assign mem_addr     = dem_issue ? dem_addr : (pf_issue ? pf_addr_q[pf_rd_q] : '0);
  assign orl_push     = mem_en;
  assign pf_push      = pf_valid && (!pf_full || pf_pop) && !pf_dup;

  assign ret_valid     = orl_pop;
  assign ret_addr      = orl_empty ? '1 : orl_addr_q[orl_rd_q];
  assign ret_is_demand = !orl_empty && orl_dem_q[orl_rd_q];
  assign err_underflow = err_q;

`ifdef MEM_REQ_DEDUP_EN
  logic [ORL_DEPTH-1:0] orl_live;
  logic [PF_DEPTH-1:0]  pf_live, dem_pf_hit;
  logic                 pf_tbl_hit;

  // Live entries; the head leaving this cycle no longer counts as outstanding.
  always_comb begin
    orl_live = '0;
    pf_live  = '0;
    for (int i = 0; i < ORL_DEPTH; i++) begin
      orl_live[i] = (OCW'(OPW'(OPW'(i) - orl_rd_q)) < orl_cnt_q) &&
                    !(orl_pop && (OPW'(i) == orl_rd_q));
    end
    for (int j = 0; j < PF_DEPTH; j++) begin
      pf_live[j] = (PCW'(PPW'(PPW'(j) - pf_rd_q)) < pf_cnt_q);
    end
  end

  always_comb begin
    dem_orl_hit = 1'b0;
    pf_tbl_hit  = 1'b0;
    dem_pf_hit  = '0;
    for (int i = 0; i < ORL_DEPTH; i++) begin
      if (orl_live[i] && (orl_addr_q[i][AW-1:2] == dem_addr[AW-1:2])) dem_orl_hit = 1'b1;
      if (orl_live[i] && (orl_addr_q[i][AW-1:2] == pf_addr[AW-1:2]))  pf_tbl_hit  = 1'b1;
    end
    for (int j = 0; j < PF_DEPTH; j++) begin
      if (pf_live[j] && (pf_addr_q[j][AW-1:2] == dem_addr[AW-1:2])) dem_pf_hit[j] = 1'b1;
      if (pf_live[j] && (pf_addr_q[j][AW-1:2] == pf_addr[AW-1:2]))  pf_tbl_hit    = 1'b1;
    end
  end

  assign kill_set = dem_issue ? dem_pf_hit : '0;
  assign pf_dup   = pf_tbl_hit || (mem_en && (mem_addr[AW-1:2] == pf_addr[AW-1:2]));
`else
  assign dem_orl_hit = 1'b0;
  assign kill_set    = '0;
  assign pf_dup      = 1'b0;
`endif

  // Next-state for both queues and the sticky underflow flag.
  always_comb begin
    orl_addr_d = orl_addr_q;
    orl_dem_d  = orl_dem_q;
    orl_rd_d   = orl_rd_q;
    orl_wr_d   = orl_wr_q;
    orl_cnt_d  = orl_cnt_q + OCW'(orl_push) - OCW'(orl_pop);
    pf_addr_d  = pf_addr_q;
    pf_kill_d  = pf_kill_q | kill_set;
    pf_rd_d    = pf_rd_q;
    pf_wr_d    = pf_wr_q;
    pf_cnt_d   = pf_cnt_q + PCW'(pf_push) - PCW'(pf_pop);
    err_d      = err_q || (mem_ready && orl_empty);
    if (orl_push) begin
      orl_addr_d[orl_wr_q] = mem_addr;
      orl_dem_d[orl_wr_q]  = dem_issue;
      orl_wr_d             = orl_wr_q + OPW'(1);
    end
    if (orl_pop) orl_rd_d = orl_rd_q + OPW'(1);
    if (pf_push) begin
      pf_addr_d[pf_wr_q] = pf_addr;
      pf_kill_d[pf_wr_q] = 1'b0;
      pf_wr_d            = pf_wr_q + PPW'(1);
    end
    if (pf_pop) pf_rd_d = pf_rd_q + PPW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ORL_DEPTH; i++) orl_addr_q[i] <= '0;
      for (int j = 0; j < PF_DEPTH; j++) pf_addr_q[j] <= '0;
      orl_dem_q <= '0;
      orl_rd_q  <= '0;
      orl_wr_q  <= '0;
      orl_cnt_q <= '0;
      pf_kill_q <= '0;
      pf_rd_q   <= '0;
      pf_wr_q   <= '0;
      pf_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      orl_addr_q <= orl_addr_d;
      pf_addr_q  <= pf_addr_d;
      orl_dem_q  <= orl_dem_d;
      orl_rd_q   <= orl_rd_d;
      orl_wr_q   <= orl_wr_d;
      orl_cnt_q  <= orl_cnt_d;
      pf_kill_q  <= pf_kill_d;
      pf_rd_q    <= pf_rd_d;
      pf_wr_q    <= pf_wr_d;
      pf_cnt_q   <= pf_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter; expectations adapt to MEM_REQ_DEDUP_EN.
module tb_mem_request_arbiter;

  logic        clk, rst_n;
  logic        dem_valid, pf_valid, mem_ready;
  logic [15:0] dem_addr, pf_addr;
  logic        dem_stall, dem_inflight, pf_full, mem_en, ret_valid, ret_is_demand, err_underflow;
  logic [15:0] mem_addr, ret_addr;
  int          checks, errors;

  mem_request_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .dem_valid(dem_valid), .dem_addr(dem_addr), .dem_stall(dem_stall), .dem_inflight(dem_inflight),
    .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_full(pf_full),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_is_demand(ret_is_demand),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    dem_valid = 1'b0; dem_addr = 16'h0; pf_valid = 1'b0; pf_addr = 16'h0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue_demands(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      idle();
      dem_valid = 1'b1;
      dem_addr  = 16'(base * 16'(k + 1));
    end
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_en, dem_stall, dem_inflight, pf_full, ret_valid, err_underflow} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 000000",
        {mem_en, dem_stall, dem_inflight, pf_full, ret_valid, err_underflow}); end
    checks++; if (ret_addr !== 16'hFFFF) begin errors++; $display("FAIL reset_ret_addr got %h exp ffff", ret_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    issue_demands(16'h0010, 3);
    @(negedge clk); idle(); #1;
    checks++; if (dut.orl_cnt_q !== 3'd3) begin errors++; $display("FAIL mid_orl_cnt got %0d exp 3", dut.orl_cnt_q); end
    checks++; if (ret_addr !== 16'h0010) begin errors++; $display("FAIL mid_ret_addr got %h exp 0010", ret_addr); end
    rst_n = 1'b0; #1;
    checks++; if (ret_addr !== 16'hFFFF) begin errors++; $display("FAIL mid_rst_ret_addr got %h exp ffff", ret_addr); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL mid_rst_mem_en got %b exp 0", mem_en); end
    checks++; if ({dut.orl_cnt_q, dut.pf_cnt_q} !== 6'd0) begin
      errors++; $display("FAIL mid_rst_counts got %0d/%0d exp 0/0", dut.orl_cnt_q, dut.pf_cnt_q); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk); idle(); pf_valid = 1'b1; pf_addr = 16'h0080; #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL prio_empty_mem_en got %b exp 0", mem_en); end
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0040; #1;
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0040}) begin
      errors++; $display("FAIL prio_dem got en=%b addr=%h exp en=1 addr=0040", mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0080}) begin
      errors++; $display("FAIL prio_pf got en=%b addr=%h exp en=1 addr=0080", mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if ({mem_en, ret_addr, ret_is_demand, dut.orl_cnt_q} !== {1'b0, 16'h0040, 1'b1, 3'd2}) begin
      errors++; $display("FAIL prio_after got en=%b ret=%h isdem=%b cnt=%0d exp en=0 ret=0040 isdem=1 cnt=2",
        mem_en, ret_addr, ret_is_demand, dut.orl_cnt_q); end
  endtask

  task automatic test_orl_full();
    do_reset();
    issue_demands(16'h0010, 4);
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0100; #1;
    checks++; if ({dem_stall, mem_en, ret_valid} !== 3'b100) begin
      errors++; $display("FAIL full_stall got stall=%b en=%b rv=%b exp 1,0,0", dem_stall, mem_en, ret_valid); end
    mem_ready = 1'b1; #1;
    checks++; if ({ret_valid, ret_addr, dem_stall} !== {1'b1, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL full_ret got rv=%b ret=%h stall=%b exp 1,0010,0", ret_valid, ret_addr, dem_stall); end
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0100}) begin
      errors++; $display("FAIL full_issue got en=%b addr=%h exp en=1 addr=0100", mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if ({ret_addr, dut.orl_cnt_q} !== {16'h0020, 3'd4}) begin
      errors++; $display("FAIL full_after got ret=%h cnt=%0d exp 0020 4", ret_addr, dut.orl_cnt_q); end
  endtask

  task automatic test_dedup_inflight();
    do_reset();
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0041;
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0042; pf_valid = 1'b1; pf_addr = 16'h0043; #1;
`ifdef MEM_REQ_DEDUP_EN
    checks++; if ({dem_inflight, mem_en, dem_stall} !== 3'b100) begin
      errors++; $display("FAIL dedup_inflight got inf=%b en=%b stall=%b exp 1,0,0", dem_inflight, mem_en, dem_stall); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.pf_cnt_q !== 3'd0) begin errors++; $display("FAIL dedup_pf_drop got %0d exp 0", dut.pf_cnt_q); end
`else
    checks++; if ({dem_inflight, mem_en, mem_addr} !== {2'b01, 16'h0042}) begin
      errors++; $display("FAIL nodedup_dem got inf=%b en=%b addr=%h exp 0,1,0042", dem_inflight, mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if ({dut.pf_cnt_q, mem_en, mem_addr} !== {3'd1, 1'b1, 16'h0043}) begin
      errors++; $display("FAIL nodedup_pf got cnt=%0d en=%b addr=%h exp 1,1,0043", dut.pf_cnt_q, mem_en, mem_addr); end
`endif
  endtask

  task automatic test_kill();
    do_reset();
    @(negedge clk); idle(); pf_valid = 1'b1; pf_addr = 16'h0200;
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0201; #1;
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0201}) begin
      errors++; $display("FAIL kill_dem got en=%b addr=%h exp en=1 addr=0201", mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
`ifdef MEM_REQ_DEDUP_EN
    checks++; if ({mem_en, dut.pf_cnt_q} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL kill_bubble got en=%b cnt=%0d exp 0 1", mem_en, dut.pf_cnt_q); end
    @(negedge clk); idle(); #1;
    checks++; if ({mem_en, dut.pf_cnt_q, dut.orl_cnt_q, ret_addr} !== {1'b0, 3'd0, 3'd1, 16'h0201}) begin
      errors++; $display("FAIL kill_after got en=%b pf=%0d orl=%0d ret=%h exp 0,0,1,0201",
        mem_en, dut.pf_cnt_q, dut.orl_cnt_q, ret_addr); end
`else
    checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0200}) begin
      errors++; $display("FAIL nokill_pf got en=%b addr=%h exp en=1 addr=0200", mem_en, mem_addr); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.orl_cnt_q !== 3'd2) begin errors++; $display("FAIL nokill_cnt got %0d exp 2", dut.orl_cnt_q); end
`endif
  endtask

  task automatic test_pf_full();
    do_reset();
    issue_demands(16'h0010, 4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); pf_valid = 1'b1; pf_addr = 16'(16'h1000 + 16'(k * 16'h0100));
    end
    @(negedge clk); idle(); pf_valid = 1'b1; pf_addr = 16'h0300; #1;
    checks++; if ({pf_full, mem_en} !== 2'b10) begin
      errors++; $display("FAIL pf_full got full=%b en=%b exp 1,0", pf_full, mem_en); end
    @(negedge clk); idle(); #1;
    checks++; if (dut.pf_cnt_q !== 3'd4) begin errors++; $display("FAIL pf_drop_cnt got %0d exp 4", dut.pf_cnt_q); end
    mem_ready = 1'b1; #1;
    checks++; if ({ret_addr, mem_en, mem_addr} !== {16'h0010, 1'b1, 16'h1000}) begin
      errors++; $display("FAIL pf_drain got ret=%h en=%b addr=%h exp 0010,1,1000", ret_addr, mem_en, mem_addr); end
  endtask

  task automatic test_underflow();
    do_reset();
    @(negedge clk); idle(); mem_ready = 1'b1; #1;
    checks++; if ({ret_valid, err_underflow, ret_addr} !== {2'b00, 16'hFFFF}) begin
      errors++; $display("FAIL uf_cycle got rv=%b err=%b ret=%h exp 0,0,ffff", ret_valid, err_underflow, ret_addr); end
    @(negedge clk); idle(); #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", err_underflow); end
    @(negedge clk); idle(); dem_valid = 1'b1; dem_addr = 16'h0050;
    @(negedge clk); idle(); mem_ready = 1'b1; #1;
    checks++; if ({ret_valid, ret_addr, ret_is_demand} !== {1'b1, 16'h0050, 1'b1}) begin
      errors++; $display("FAIL uf_ret got rv=%b ret=%h isdem=%b exp 1,0050,1", ret_valid, ret_addr, ret_is_demand); end
    @(negedge clk); idle(); @(negedge clk); #1;
    checks++; if ({err_underflow, ret_addr} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL uf_sticky got err=%b ret=%h exp 1,ffff", err_underflow, ret_addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid_traffic();
    test_priority();
    test_orl_full();
    test_dedup_inflight();
    test_kill();
    test_pf_full();
    test_underflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
